// File: rtl/random_math_pkg.sv
// random_math_pkg: shared constants for the CNv4 random-math interpreter.
//   - opcode values, FSM state encoding, err_code values
//   - instruction field offsets, relative to DATA_W
//     (opcode at [DATA_W+OPC_OFS -: 8], dst at [DATA_W+DST_OFS -: 8],
//      src at [DATA_W+SRC_OFS -: 8], imm at [DATA_W-1:0])
package random_math_pkg;

    localparam logic [7:0] OP_MUL = 8'd0;
    localparam logic [7:0] OP_ADD = 8'd1;
    localparam logic [7:0] OP_SUB = 8'd2;
    localparam logic [7:0] OP_ROR = 8'd3;
    localparam logic [7:0] OP_ROL = 8'd4;
    localparam logic [7:0] OP_XOR = 8'd5;
    localparam logic [7:0] OP_RET = 8'd6;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_MUL2  = 3'd4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_INDEX   = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam int OPC_OFS = 23;
    localparam int DST_OFS = 15;
    localparam int SRC_OFS = 7;

endpackage

// File: rtl/random_math_alu.sv
// random_math_alu: combinational datapath for one random-math instruction.
//   op      in  8       opcode
//   d, s    in  DATA_W  destination / source operand values
//   imm     in  DATA_W  immediate (ADD only)
//   result  out DATA_W  value to write back to dst
//   illegal out 1       opcode above RET
module random_math_alu
    import random_math_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [7:0]        op,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] s,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              illegal
);
    localparam int SW = $clog2(DATA_W);

    logic [SW-1:0]         sh;
    logic [2*DATA_W-1:0]   rr;
    logic [2*DATA_W-1:0]   rl;

    // Rotates via a doubled operand: the low half of {d,d}>>sh is ror,
    // the high half of {d,d}<<sh is rol; sh==0 naturally yields d.
    assign sh = s[SW-1:0];
    assign rr = {d, d} >> sh;
    assign rl = {d, d} << sh;

    always_comb begin
        result = '0;
        case (op)
            OP_MUL:  result = d * s;
            OP_ADD:  result = d + s + imm;
            OP_SUB:  result = d - s;
            OP_ROR:  result = rr[DATA_W-1:0];
            OP_ROL:  result = rl[2*DATA_W-1 -: DATA_W];
            OP_XOR:  result = d ^ s;
            default: result = '0;
        endcase
    end

    assign illegal = (op > OP_RET);

endmodule

// File: rtl/random_math_vm.sv
// random_math_vm: parametrised CNv4 random-math interpreter.
// Fetches instructions from a synchronous program RAM (1-cycle latency),
// executes them on a NUM_REGS x DATA_W register file until RET, then
// pulses done.
//   clk, reset   clock, synchronous active-high reset
//   start        launch, honoured only in IDLE
//   regs_in      initial registers, reg i at [i*DATA_W +: DATA_W]
//   prog_addr    registered program RAM address
//   prog_rdata   RAM data, valid one cycle after prog_addr
//   busy, done   run in progress / one-cycle end-of-run pulse
//   err_code     0 none, 1 illegal opcode, 2 bad index, 3 overrun
//   regs_out     register file, same packing as regs_in
// Build option: RANDOM_MATH_MUL_PIPE_EN registers MUL operands in EXEC
// and writes the product in an extra MUL2 state.
module random_math_vm
    import random_math_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 9,
    parameter int PROG_AW  = 7,
    parameter int INSN_W   = DATA_W + 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_REGS*DATA_W-1:0]   regs_in,
    output logic [PROG_AW-1:0]           prog_addr,
    input  logic [INSN_W-1:0]            prog_rdata,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   err_code,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out
);
    logic [2:0]                           state;
    logic [NUM_REGS-1:0][DATA_W-1:0]      regs;

    logic [7:0]        op, dst, src;
    logic [DATA_W-1:0] imm, d, s, res;
    logic              illegal, idx_ok, last_addr;

    assign op  = prog_rdata[DATA_W+OPC_OFS -: 8];
    assign dst = prog_rdata[DATA_W+DST_OFS -: 8];
    assign src = prog_rdata[DATA_W+SRC_OFS -: 8];
    assign imm = prog_rdata[DATA_W-1:0];

    assign idx_ok    = (int'(dst) < NUM_REGS) && (int'(src) < NUM_REGS);
    assign last_addr = &prog_addr;

    // Operand read by compare-select so out-of-range indices never
    // produce an out-of-bounds array access.
    always_comb begin
        d = '0;
        s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(dst) == i) d = regs[i];
            if (int'(src) == i) s = regs[i];
        end
    end

    random_math_alu #(.DATA_W(DATA_W)) u_alu (
        .op      (op),
        .d       (d),
        .s       (s),
        .imm     (imm),
        .result  (res),
        .illegal (illegal)
    );

`ifdef RANDOM_MATH_MUL_PIPE_EN
    logic [DATA_W-1:0] mul_a, mul_b, mul_p;
    logic [7:0]        mul_dst;
    assign mul_p = mul_a * mul_b;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            prog_addr <= '0;
            err_code  <= ERR_NONE;
            regs      <= '0;
`ifdef RANDOM_MATH_MUL_PIPE_EN
            mul_a     <= '0;
            mul_b     <= '0;
            mul_dst   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    regs      <= regs_in;
                    prog_addr <= '0;
                    err_code  <= ERR_NONE;
                    state     <= ST_FETCH;
                end
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC: begin
                    if (op == OP_RET) begin
                        state <= ST_DONE;
                    end else if (illegal) begin
                        if (err_code == ERR_NONE) err_code <= ERR_ILLEGAL;
                        state <= ST_DONE;
`ifdef RANDOM_MATH_MUL_PIPE_EN
                    end else if (idx_ok && op == OP_MUL) begin
                        mul_a   <= d;
                        mul_b   <= s;
                        mul_dst <= dst;
                        state   <= ST_MUL2;
`endif
                    end else begin
                        for (int i = 0; i < NUM_REGS; i++)
                            if (idx_ok && int'(dst) == i) regs[i] <= res;
                        if (last_addr) begin
                            state <= ST_DONE;
                            if (err_code == ERR_NONE) err_code <= ERR_OVERRUN;
                        end else begin
                            prog_addr <= prog_addr + 1'b1;
                            state     <= ST_FETCH;
                        end
                        // Placed after the overrun update so a bad index on
                        // the last address still reports as the earlier error.
                        if (!idx_ok && err_code == ERR_NONE) err_code <= ERR_INDEX;
                    end
                end
`ifdef RANDOM_MATH_MUL_PIPE_EN
                ST_MUL2: begin
                    for (int i = 0; i < NUM_REGS; i++)
                        if (int'(mul_dst) == i) regs[i] <= mul_p;
                    if (last_addr) begin
                        state <= ST_DONE;
                        if (err_code == ERR_NONE) err_code <= ERR_OVERRUN;
                    end else begin
                        prog_addr <= prog_addr + 1'b1;
                        state     <= ST_FETCH;
                    end
                end
`endif
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign done     = (state == ST_DONE);
    assign busy     = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_MUL2);
    assign regs_out = regs;

endmodule

// File: tb/tb_random_math_vm.sv
// tb_random_math_vm: directed self-checking bench for random_math_vm
// (default 32-bit, 9-register, 128-entry configuration).
module tb_random_math_vm;
    localparam int DW = 32;
    localparam int NR = 9;
    localparam int AW = 7;
    localparam int IW = DW + 24;
`ifdef RANDOM_MATH_MUL_PIPE_EN
    localparam int MX = 1;
`else
    localparam int MX = 0;
`endif

    logic              clk = 0;
    logic              reset;
    logic              start;
    logic [NR*DW-1:0]  regs_in;
    logic [AW-1:0]     prog_addr;
    logic [IW-1:0]     prog_rdata;
    logic              busy, done;
    logic [1:0]        err_code;
    logic [NR*DW-1:0]  regs_out;

    logic [IW-1:0]     mem [0:(1<<AW)-1];
    int                total = 0;
    int                bad = 0;
    int                cyc;
    logic [NR*DW-1:0]  saved;
    bit                saw_done;

    random_math_vm #(.DATA_W(DW), .NUM_REGS(NR), .PROG_AW(AW), .INSN_W(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .regs_in    (regs_in),
        .prog_addr  (prog_addr),
        .prog_rdata (prog_rdata),
        .busy       (busy),
        .done       (done),
        .err_code   (err_code),
        .regs_out   (regs_out)
    );

    always #5 clk = ~clk;

    // Synchronous program RAM, one-cycle read latency.
    always @(posedge clk) prog_rdata <= mem[prog_addr];

    function automatic logic [IW-1:0] insn(input logic [7:0] op, input logic [7:0] dd,
                                           input logic [7:0] ss, input logic [DW-1:0] im);
        return {op, dd, ss, im};
    endfunction

    function automatic logic [DW-1:0] rget(input int i);
        return regs_out[i*DW +: DW];
    endfunction

    task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < (1 << AW); i++) mem[i] = insn(8'd6, 8'd0, 8'd0, '0);
    endtask

    // Launch a run; cycle 1 is the first cycle after acceptance. When the
    // run reaches cycle 'poke', start is pulsed again with junk regs_in.
    task automatic run(input int poke, output int c);
        @(negedge clk); start = 1;
        @(posedge clk); #1 start = 0;
        c = 1;
        while (c < 1000) begin
            @(negedge clk);
            start = 0;
            if (done) break;
            if (c == poke) begin start = 1; regs_in = '1; end
            @(posedge clk); c++;
        end
        start = 0;
    endtask

    initial begin
        reset = 1; start = 0; regs_in = '0;
        clear_prog();
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", prog_addr, 0);
        chk("rst_err", err_code, 0);
        chk("rst_regs", regs_out, 0);

        // MUL r0,r1 ; RET
        clear_prog();
        regs_in = '0; regs_in[0*DW +: DW] = 3; regs_in[1*DW +: DW] = 5;
        mem[0] = insn(8'd0, 8'd0, 8'd1, '0);
        run(-1, cyc);
        chk("mul_cyc", cyc, 5 + MX);
        chk("mul_r0", rget(0), 15);
        chk("mul_r1", rget(1), 5);
        chk("mul_err", err_code, 0);
        chk("mul_busy_at_done", busy, 0);
        @(negedge clk);
        chk("mul_done_pulse", done, 0);

        // ADD wrap: 1 + 0 + 0xFFFFFFFF
        clear_prog();
        regs_in = '0; regs_in[2*DW +: DW] = 1;
        mem[0] = insn(8'd1, 8'd2, 8'd3, 32'hFFFF_FFFF);
        run(-1, cyc);
        chk("add_cyc", cyc, 5);
        chk("add_r2", rget(2), 0);

        // ROR by 33 (=1), clear r1 via SUB, ROL by 0
        clear_prog();
        regs_in = '0; regs_in[0*DW +: DW] = 1; regs_in[1*DW +: DW] = 33;
        mem[0] = insn(8'd3, 8'd0, 8'd1, '0);
        mem[1] = insn(8'd2, 8'd1, 8'd1, '0);
        mem[2] = insn(8'd4, 8'd0, 8'd1, '0);
        run(-1, cyc);
        chk("rot_cyc", cyc, 9);
        chk("rot_r0", rget(0), 32'h8000_0000);
        chk("rot_r1", rget(1), 0);

        // Mixed: ROL by 4, XOR, SUB with updated operand, ADD dst==src
        clear_prog();
        regs_in = '0;
        regs_in[0*DW +: DW] = 32'h8000_0001; regs_in[2*DW +: DW] = 4;
        regs_in[4*DW +: DW] = 32'hF0F0_F0F0; regs_in[5*DW +: DW] = 32'hFF00_FF00;
        regs_in[6*DW +: DW] = 10;
        mem[0] = insn(8'd4, 8'd0, 8'd2, '0);
        mem[1] = insn(8'd5, 8'd4, 8'd5, '0);
        mem[2] = insn(8'd2, 8'd5, 8'd4, '0);
        mem[3] = insn(8'd1, 8'd6, 8'd6, 32'd7);
        run(-1, cyc);
        chk("mix_cyc", cyc, 11);
        chk("mix_rol", rget(0), 32'h0000_0018);
        chk("mix_xor", rget(4), 32'h0FF0_0FF0);
        chk("mix_sub", rget(5), 32'hEF10_EF10);
        chk("mix_add", rget(6), 27);
        chk("mix_err", err_code, 0);

        // Illegal opcode at address 0
        clear_prog();
        for (int i = 0; i < NR; i++) regs_in[i*DW +: DW] = 32'h1111_0000 + i;
        saved = regs_in;
        mem[0] = insn(8'h09, 8'd0, 8'd1, '0);
        run(-1, cyc);
        chk("ill_cyc", cyc, 3);
        chk("ill_err", err_code, 1);
        chk("ill_regs", regs_out, saved);

        // Bad index, then XOR r0,r0 ; RET
        clear_prog();
        regs_in = '0; regs_in[0*DW +: DW] = 32'h1234;
        mem[0] = insn(8'd5, 8'd12, 8'd0, '0);
        mem[1] = insn(8'd5, 8'd0, 8'd0, '0);
        run(-1, cyc);
        chk("idx_cyc", cyc, 7);
        chk("idx_r0", rget(0), 0);
        chk("idx_err", err_code, 2);

        // First error wins: bad index then illegal opcode
        clear_prog();
        mem[0] = insn(8'd1, 8'd0, 8'd200, '0);
        mem[1] = insn(8'hFF, 8'd0, 8'd0, '0);
        run(-1, cyc);
        chk("first_cyc", cyc, 5);
        chk("first_err", err_code, 2);

        // start pulsed mid-run is ignored
        clear_prog();
        regs_in = '0; regs_in[2*DW +: DW] = 1; regs_in[4*DW +: DW] = 32'hABCD;
        mem[0] = insn(8'd1, 8'd2, 8'd3, 32'hFFFF_FFFF);
        run(2, cyc);
        chk("ign_cyc", cyc, 5);
        chk("ign_r2", rget(2), 0);
        chk("ign_r4", rget(4), 32'hABCD);

        // Overrun: 128 ADD r1,r2,+1 instructions, no RET
        for (int i = 0; i < (1 << AW); i++) mem[i] = insn(8'd1, 8'd1, 8'd2, 32'd1);
        regs_in = '0;
        run(-1, cyc);
        chk("ovr_cyc", cyc, 257);
        chk("ovr_err", err_code, 3);
        chk("ovr_r1", rget(1), 128);
        chk("ovr_addr", prog_addr, 127);

        // Reset mid-run aborts with no done pulse
        regs_in = '0; regs_in[1*DW +: DW] = 32'h55;
        @(negedge clk); start = 1;
        @(posedge clk); #1 start = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("mid_busy_before", busy, 1);
        reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_addr", prog_addr, 0);
        chk("mid_regs", regs_out, 0);
        chk("mid_err", err_code, 0);
        saw_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        chk("mid_no_done", saw_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
